// File: rtl/rv32i_rtype_decoder.sv
// rv32i_rtype_decoder
// Registered RV32I R-type decoder. It extracts the register indices and funct
// fields, maps {funct7, funct3} to an ALU operation code, flags anything that
// is not a supported R-type op, and keeps a saturating count of illegal decodes.
module rv32i_rtype_decoder #(
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [31:0]          instr,
    output logic                 out_valid,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [2:0]           funct3,
    output logic [6:0]           funct7,
    output logic                 RegWrite,
    output logic [3:0]           ALUOp,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_INV  = 4'd15;

    localparam logic [ILL_CNT_W-1:0] ILL_CNT_MAX = {ILL_CNT_W{1'b1}};
    localparam logic [ILL_CNT_W-1:0] ILL_CNT_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

    // Maps {funct7, funct3} of an R-type word to {illegal, ALUOp}.
    function automatic logic [4:0] rtype_lookup(input logic [6:0] f7, input logic [2:0] f3);
        logic [4:0] res;
        case ({f7, f3})
            10'b0000000_000: res = {1'b0, ALU_ADD};
            10'b0000000_001: res = {1'b0, ALU_SLL};
            10'b0000000_010: res = {1'b0, ALU_SLT};
            10'b0000000_011: res = {1'b0, ALU_SLTU};
            10'b0000000_100: res = {1'b0, ALU_XOR};
            10'b0000000_101: res = {1'b0, ALU_SRL};
            10'b0000000_110: res = {1'b0, ALU_OR};
            10'b0000000_111: res = {1'b0, ALU_AND};
            10'b0100000_000: res = {1'b0, ALU_SUB};
            10'b0100000_101: res = {1'b0, ALU_SRA};
            default:         res = {1'b1, ALU_INV};
        endcase
        return res;
    endfunction

    logic [3:0] dec_alu_op_s;
    logic       dec_illegal_s;
    logic       dec_reg_write_s;
    logic [4:0] dec_rs2_s;

    // Combinational decode of the incoming word; rs2 only exists for R-type.
    always_comb begin
        dec_alu_op_s    = ALU_INV;
        dec_illegal_s   = 1'b1;
        dec_reg_write_s = 1'b0;
        dec_rs2_s       = 5'd0;
        if (instr[6:0] == OPC_RTYPE) begin
            {dec_illegal_s, dec_alu_op_s} = rtype_lookup(instr[31:25], instr[14:12]);
            dec_reg_write_s = 1'b1;
            dec_rs2_s       = instr[24:20];
        end else begin
            dec_alu_op_s    = ALU_INV;
            dec_illegal_s   = 1'b1;
            dec_reg_write_s = 1'b0;
            dec_rs2_s       = 5'd0;
        end
    end

    // Output register: reset wins, valid words load a fresh decode, idle cycles hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rs1       <= 5'd0;
            rs2       <= 5'd0;
            rd        <= 5'd0;
            funct3    <= 3'd0;
            funct7    <= 7'd0;
            RegWrite  <= 1'b0;
            ALUOp     <= ALU_INV;
            illegal   <= 1'b0;
            ill_count <= {ILL_CNT_W{1'b0}};
        end else if (in_valid) begin
            out_valid <= 1'b1;
            rs1       <= instr[19:15];
            rs2       <= dec_rs2_s;
            rd        <= instr[11:7];
            funct3    <= instr[14:12];
            funct7    <= instr[31:25];
            RegWrite  <= dec_reg_write_s;
            ALUOp     <= dec_alu_op_s;
            illegal   <= dec_illegal_s;
            if (dec_illegal_s && (ill_count != ILL_CNT_MAX)) begin
                ill_count <= ill_count + ILL_CNT_ONE;
            end else begin
                ill_count <= ill_count;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_rtype_decoder.sv
// Bench for rv32i_rtype_decoder: directed steps followed by random words, all
// checked against a table-driven reference model. A second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_rv32i_rtype_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;

    logic        out_valid;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        RegWrite;
    logic [3:0]  ALUOp;
    logic        illegal;
    logic [15:0] ill_count;

    logic        s_out_valid;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [2:0]  s_funct3;
    logic [6:0]  s_funct7;
    logic        s_RegWrite;
    logic [3:0]  s_ALUOp;
    logic        s_illegal;
    logic [1:0]  s_ill_count;

    rv32i_rtype_decoder #(.ILL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr),
        .out_valid(out_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
        .funct3(funct3), .funct7(funct7), .RegWrite(RegWrite),
        .ALUOp(ALUOp), .illegal(illegal), .ill_count(ill_count)
    );

    rv32i_rtype_decoder #(.ILL_CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr),
        .out_valid(s_out_valid), .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd),
        .funct3(s_funct3), .funct7(s_funct7), .RegWrite(s_RegWrite),
        .ALUOp(s_ALUOp), .illegal(s_illegal), .ill_count(s_ill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int op_map[int];
    int e_valid, e_rs1, e_rs2, e_rd, e_f3, e_f7, e_rw, e_op, e_ill;
    int e_cnt, e_cnt_small;

    function automatic logic [31:0] mk(input int f7, input int r2, input int r1,
                                       input int f3, input int rdi, input int opc);
        logic [31:0] w;
        w = {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rdi[4:0], opc[6:0]};
        return w;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_valid = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_f3 = 0; e_f7 = 0;
        e_rw = 0; e_op = 15; e_ill = 0; e_cnt = 0; e_cnt_small = 0;
    endtask

    // Model of one accepted word, straight from the field layout and op table.
    task automatic model_decode(input logic [31:0] w);
        int opc, f7, f3, key;
        opc = int'(w[6:0]);
        f7  = int'(w[31:25]);
        f3  = int'(w[14:12]);
        key = f7 * 8 + f3;
        e_valid = 1;
        e_rd  = int'(w[11:7]);
        e_rs1 = int'(w[19:15]);
        e_f3  = f3;
        e_f7  = f7;
        if (opc == 51) begin
            e_rw  = 1;
            e_rs2 = int'(w[24:20]);
            if (op_map.exists(key)) begin
                e_op = op_map[key]; e_ill = 0;
            end else begin
                e_op = 15; e_ill = 1;
            end
        end else begin
            e_rw = 0; e_rs2 = 0; e_op = 15; e_ill = 1;
        end
        if (e_ill == 1) begin
            if (e_cnt < 65535) e_cnt++;
            if (e_cnt_small < 3) e_cnt_small++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, int'(out_valid), e_valid);
        chk({tag, ".rd"},        int'(rd),        e_rd);
        chk({tag, ".rs1"},       int'(rs1),       e_rs1);
        chk({tag, ".rs2"},       int'(rs2),       e_rs2);
        chk({tag, ".funct3"},    int'(funct3),    e_f3);
        chk({tag, ".funct7"},    int'(funct7),    e_f7);
        chk({tag, ".RegWrite"},  int'(RegWrite),  e_rw);
        chk({tag, ".ALUOp"},     int'(ALUOp),     e_op);
        chk({tag, ".illegal"},   int'(illegal),   e_ill);
        chk({tag, ".ill_count"}, int'(ill_count), e_cnt);
        chk({tag, ".small_cnt"}, int'(s_ill_count), e_cnt_small);
        chk({tag, ".small_op"},  int'(s_ALUOp),   e_op);
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input string tag, input logic r, input logic v, input logic [31:0] w);
        @(negedge clk);
        rst_n = r; in_valid = v; instr = w;
        @(posedge clk);
        if (!r) model_reset();
        else if (v) model_decode(w);
        else e_valid = 0;
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] w;
        int sel;
        op_map[0]   = 0;  op_map[1] = 5;  op_map[2] = 8;  op_map[3] = 9;
        op_map[4]   = 4;  op_map[5] = 6;  op_map[6] = 3;  op_map[7] = 2;
        op_map[256] = 1;  op_map[261] = 7;
        model_reset();
        rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0;

        step("reset", 1'b0, 1'b0, 32'd0);
        step("add",  1'b1, 1'b1, mk(0, 7, 6, 0, 5, 51));
        chk("add.const_op", int'(ALUOp), 0);
        chk("add.const_rw", int'(RegWrite), 1);
        step("sub",  1'b1, 1'b1, mk(32, 10, 9, 0, 8, 51));
        chk("sub.const_op", int'(ALUOp), 1);
        step("sra",  1'b1, 1'b1, mk(32, 6, 5, 5, 4, 51));
        chk("sra.const_op", int'(ALUOp), 7);
        step("sll",  1'b1, 1'b1, mk(0, 3, 4, 1, 9, 51));
        step("slt",  1'b1, 1'b1, mk(0, 11, 12, 2, 13, 51));
        step("sltu", 1'b1, 1'b1, mk(0, 14, 15, 3, 16, 51));
        step("xor",  1'b1, 1'b1, mk(0, 17, 18, 4, 19, 51));
        step("srl",  1'b1, 1'b1, mk(0, 20, 21, 5, 22, 51));
        step("or",   1'b1, 1'b1, mk(0, 23, 24, 6, 25, 51));
        step("and",  1'b1, 1'b1, mk(0, 1, 2, 7, 3, 51));
        chk("and.const_op", int'(ALUOp), 2);
        step("ill_r", 1'b1, 1'b1, mk(32, 3, 2, 1, 1, 51));
        chk("ill_r.const_cnt", int'(ill_count), 1);
        step("mul",  1'b1, 1'b1, mk(1, 5, 6, 0, 7, 51));
        step("addi", 1'b1, 1'b1, {12'd7, 5'd2, 3'b000, 5'd1, 7'b0010011});
        chk("addi.const_rs2", int'(rs2), 0);
        step("hold1", 1'b1, 1'b0, mk(0, 31, 31, 0, 31, 51));
        step("hold2", 1'b1, 1'b0, 32'hffff_ffff);
        step("rst_pri", 1'b0, 1'b1, mk(32, 3, 2, 1, 1, 51));
        for (int i = 0; i < 5; i++) begin
            step("sat", 1'b1, 1'b1, {25'd0, 7'b0010011});
        end
        chk("sat.const_small", int'(s_ill_count), 3);
        chk("sat.const_big", int'(ill_count), 5);

        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel < 6) w[6:0] = 7'b0110011;
            if (sel < 3) w[31:25] = 7'b0000000;
            else if (sel < 5) w[31:25] = 7'b0100000;
            step("rand", ($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
